// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative HI/LO multiply/divide unit for the EX stage.
// Runs MULT/MULTU/DIV/DIVU one radix-2 step per cycle. It also holds the
// HI/LO architectural registers and serves MTHI/MTLO writes.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start, op         launch request, op select (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa, opb          rs / rt operands
//   flush             abort an in-flight operation
//   hi_wen, lo_wen    MTHI / MTLO write strobes, data on wdat
//   busy              operation in flight (stall request)
//   done              one-cycle pulse after HI/LO were written by an operation
//   hi, lo            HI / LO registers
// Build option: define MULDIV_EARLY_TERM_EN to let multiplies leave BUSY as
// soon as the remaining multiplier bits are zero.
module ex_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   input  logic             hi_wen,
   input  logic             lo_wen,
   input  logic [WIDTH-1:0] wdat,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned AW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;       // product, or {remainder, quotient/dividend}
   logic [AW-1:0]    mcand_q, mcand_d;   // shifted multiplicand, or divisor in low half
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic             is_div_q, is_div_d;
   logic             neg_q_q, neg_q_d;   // product / quotient negate
   logic             neg_r_q, neg_r_d;   // remainder negate
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             busy_q, busy_d, done_q, done_d;

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   logic             sgn, sa, sb, last;
   logic [WIDTH-1:0] abs_a, abs_b, mpl_next, q_raw, r_raw;
   logic [WIDTH:0]   rem_sh, diff;
   logic [AW-1:0]    prod_sum;

   // Next-state, step datapath and HI/LO update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      sgn      = ~op[0];
      sa       = sgn & opa[WIDTH-1];
      sb       = sgn & opb[WIDTH-1];
      abs_a    = sa ? (~opa + WIDTH'(1)) : opa;
      abs_b    = sb ? (~opb + WIDTH'(1)) : opb;
      mpl_next = mplier_q >> 1;
      prod_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
      rem_sh   = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
      diff     = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
      q_raw    = acc_q[WIDTH-1:0];
      r_raw    = acc_q[AW-1:WIDTH];
`ifdef MULDIV_EARLY_TERM_EN
      last     = (cnt_q == '0) || (!is_div_q && (mpl_next == '0));
`else
      last     = (cnt_q == '0);
`endif

      // MTHI/MTLO; a completing operation below takes precedence
      if (hi_wen) hi_d = wdat;
      if (lo_wen) lo_d = wdat;

      case (state_q)
         S_IDLE: begin
            if (!flush && start) begin
               is_div_d = op[1];
               cnt_d    = CW'(WIDTH - 1);
               neg_q_d  = sa ^ sb;
               neg_r_d  = op[1] & sa;
               if (op[1] && (opb == '0)) begin
                  // Divide by zero: result preloaded, no iteration
                  acc_d   = {opa, {WIDTH{1'b1}}};
                  neg_q_d = 1'b0;
                  neg_r_d = 1'b0;
                  state_d = S_FIXUP;
               end else if (op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, abs_a};
                  mcand_d = {{WIDTH{1'b0}}, abs_b};
                  state_d = S_BUSY;
               end else begin
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, abs_a};
                  mplier_d = abs_b;
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (is_div_q) begin
                  // Restoring step: keep the shifted remainder when the trial goes negative
                  if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                  else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end else begin
                  acc_d    = prod_sum;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mpl_next;
               end
               if (last) state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  lo_d = neg_q_q ? (~q_raw + WIDTH'(1)) : q_raw;
                  hi_d = neg_r_q ? (~r_raw + WIDTH'(1)) : r_raw;
               end else begin
                  {hi_d, lo_d} = neg_q_q ? (~acc_q + AW'(1)) : acc_q;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam int unsigned W = 32;

   logic         CLK = 1'b0;
   logic         RST, start, flush, hi_wen, lo_wen;
   logic [1:0]   op;
   logic [W-1:0] opa, opb, wdat;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_hi, exp_lo;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
      .flush(flush), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Reference result {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin q = sa * sb; p = q; end
         2'b01: p = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Edges after the start edge until done is visible
   function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ab;
      int idx;
      ab = (!o[0] && b[W-1]) ? (0 - b) : b;
      idx = 0;
      for (int i = 0; i < int'(W); i++) if (ab[i]) idx = i;
      if (o[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_TERM_EN
      if (!o[1]) return 2 + idx;
`endif
      return W + 1;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [63:0] r;
      int n;
      op = o; opa = a; opb = b; start = 1'b1;
      tick;
      start = 1'b0;
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 60) begin tick; n++; end
      check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat(o, a, b)));
      r = model(o, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      // A start presented in the DONE cycle must be dropped
      start = 1'b1;
      tick;
      start = 1'b0;
      check_eq({tag, "_idle"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      int n, ndone;
      logic [63:0] r;
      logic [1:0]  ro;
      logic [W-1:0] ra, rb;

      RST = 1'b1; start = 1'b0; flush = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
      op = 2'b00; opa = '0; opb = '0; wdat = '0;
      tick; tick;
      RST = 1'b0;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_hilo", {hi, lo}, 64'd0);
      exp_hi = '0; exp_lo = '0;

      // Directed arithmetic corners
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
      check_eq("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check_eq("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
      check_eq("div_m7d2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b11, 32'd7, 32'd0, "divu_d0");
      check_eq("divu_d0_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check_eq("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(2'b00, 32'd5, 32'd5, "mult_5x5");
      run_op(2'b10, 32'd5, 32'd0, "div_d0");

      // Flush mid-divide: no result, no done
      op = 2'b11; opa = 32'd100; opb = 32'd7; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (9) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check_eq("flush_busy", 64'(busy), 64'd0);
      ndone = 0;
      repeat (40) begin tick; if (done) ndone++; end
      check_eq("flush_nodone", 64'(ndone), 64'd0);
      check_eq("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
      run_op(2'b11, 32'd100, 32'd7, "divu_restart");
      check_eq("divu_restart_const", {hi, lo}, 64'h0000_0002_0000_000E);

      // Flush while in FIXUP (divide by zero sits there after one edge)
      op = 2'b11; opa = 32'd55; opb = 32'd0; start = 1'b1;
      tick;
      start = 1'b0; flush = 1'b1;
      tick;
      flush = 1'b0;
      check_eq("fixflush_busy", 64'({busy, done}), 64'd0);
      check_eq("fixflush_hilo", {hi, lo}, {exp_hi, exp_lo});

      // Flush together with start in IDLE drops the start
      op = 2'b01; opa = 32'd3; opb = 32'd3; start = 1'b1; flush = 1'b1;
      tick;
      start = 1'b0; flush = 1'b0;
      check_eq("flushstart_busy", 64'(busy), 64'd0);

      // MTHI/MTLO in IDLE
      hi_wen = 1'b1; lo_wen = 1'b1; wdat = 32'hCAFE_0001;
      tick;
      hi_wen = 1'b0; lo_wen = 1'b0;
      check_eq("mt_idle", {hi, lo}, 64'hCAFE_0001_CAFE_0001);

      // FIXUP beats a same-edge MTLO
      op = 2'b11; opa = 32'd9; opb = 32'd0; start = 1'b1;
      tick;
      start = 1'b0; lo_wen = 1'b1; wdat = 32'hAA;
      tick;
      lo_wen = 1'b0;
      check_eq("fixwin_done", 64'(done), 64'd1);
      check_eq("fixwin_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
      tick;

      // MTHI during BUSY plus an ignored start, then overwritten by FIXUP
      op = 2'b00; opa = 32'h0000_1111; opb = 32'hF0F0_F0F0; start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick;
      hi_wen = 1'b1; wdat = 32'h1234;
      start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd6;
      tick;
      hi_wen = 1'b0; start = 1'b0;
      check_eq("mthi_busy", 64'(hi), 64'h1234);
      n = 3;
      while (!done && n < 60) begin tick; n++; end
      check_eq("mthi_lat", 64'(n), 64'(exp_lat(2'b00, 32'h0000_1111, 32'hF0F0_F0F0)));
      r = model(2'b00, 32'h0000_1111, 32'hF0F0_F0F0);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      check_eq("mthi_result", {hi, lo}, r);
      ndone = 0;
      repeat (40) begin tick; if (done || busy) ndone++; end
      check_eq("mthi_single", 64'(ndone), 64'd0);

      // Random operations against the model
      for (int k = 0; k < 40; k++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(0, 255));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         run_op(ro, ra, rb, $sformatf("rnd%0d", k));
      end

      // Reset mid-operation clears everything and suppresses done
      op = 2'b00; opa = 32'd5; opb = 32'd5; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      check_eq("midrst_state", 64'({busy, done}), 64'd0);
      check_eq("midrst_hilo", {hi, lo}, 64'd0);
      ndone = 0;
      repeat (40) begin tick; if (done) ndone++; end
      check_eq("midrst_nodone", 64'(ndone), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
